// File: rtl/capture_pkg.sv
// Shared definitions for the capture buffer: mode encodings and depth helper.
package capture_pkg;

  localparam int CAP_LINEAR   = 0;
  localparam int CAP_CIRCULAR = 1;

  function automatic int cap_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/sdp_ram_rf.sv
// Simple-dual-port inferred RAM: port A writes, port B reads with one registered cycle, read-first.
module sdp_ram_rf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_re,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // A same-address write lands after the read samples, so port B sees the old word
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_data;
    if (b_re) b_data <= mem[b_addr];
  end

endmodule

// File: rtl/capture_buffer_ctrl.sv
// Drains a source FIFO into an SDP RAM and serves stored words to the host, in linear or circular mode.
module capture_buffer_ctrl
  import capture_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int WRAP_MODE = CAP_LINEAR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_empty,
  output logic              src_rd,
  input  logic [DATA_W-1:0] src_data,
  input  logic              clear,
  input  logic              rewind,
  input  logic              rd_en,
  output logic              rd_avail,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              overflow
);

  localparam int              DEPTH   = cap_depth(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);
  localparam logic            WRAP_EN = (WRAP_MODE == CAP_CIRCULAR);

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (v == DEPTH_L) ? v : v + ONE_L;
  endfunction

  logic [ADDR_W-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [ADDR_W:0]   stored, stored_next, level_next;
  logic [ADDR_W+1:0] space_used;
  logic              wr_pend, vld_p1;
  logic              kill, wr_fire, rd_fire, lose;

  assign kill       = rst | clear;
  assign space_used = {1'b0, level} + (ADDR_W+2)'(wr_pend);
  assign src_rd     = ~src_empty & ~kill & (WRAP_EN | (space_used < (ADDR_W+2)'(DEPTH)));
  assign full       = (level == DEPTH_L);
  assign rd_avail   = (level != '0);

  assign wr_fire = wr_pend & ~kill;
  assign rd_fire = rd_en & rd_avail & ~rewind & ~kill;
  // A write into a full buffer without a read evicts the oldest word; this also keeps
  // level bounded should a rewind raise it while a linear-mode write is in flight.
  assign lose    = wr_fire & full & ~rd_fire;

  assign wr_ptr_next = wr_ptr + ADDR_W'(wr_fire);
  assign rd_ptr_next = rd_ptr + ADDR_W'(rd_fire | lose);
  assign stored_next = wr_fire ? sat_inc(stored) : stored;

  always_comb begin
    level_next = level;
    if (wr_fire && !rd_fire && !lose) level_next = level + ONE_L;
    else if (rd_fire && !wr_fire)     level_next = level - ONE_L;
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      wr_pend  <= 1'b0;
      vld_p1   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      stored   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_pend  <= src_rd;
      vld_p1   <= rd_fire;
      wr_ptr   <= wr_ptr_next;
      stored   <= stored_next;
      overflow <= overflow | (lose & WRAP_EN);
      if (rewind) begin
        rd_ptr <= (stored == DEPTH_L) ? wr_ptr_next : '0;
        level  <= stored_next;
      end else begin
        rd_ptr <= rd_ptr_next;
        level  <= level_next;
      end
    end
  end

  sdp_ram_rf #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .a_we   (wr_fire),
    .a_addr (wr_ptr),
    .a_data (src_data),
    .b_re   (rd_fire),
    .b_addr (rd_ptr),
    .b_data (rd_data)
  );

  // p1: RAM output stage; the pulse is suppressed if reset/clear hits while it is in flight
  assign rd_valid = vld_p1 & ~kill;

endmodule

// File: tb/tb_capture_buffer_ctrl.sv
// Bench for capture_buffer_ctrl: three instances (linear/circular depth 8, default 1024) against a history-queue model.
module tb_capture_buffer_ctrl;
  import capture_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, clear = 1'b0, rewind = 1'b0, rd_en = 1'b0, src_empty = 1'b1;
  logic [31:0] src_data = '0;

  logic        l_src_rd, l_rd_avail, l_rd_valid, l_full, l_ovf;
  logic [31:0] l_rd_data;
  logic [3:0]  l_level;
  logic        c_src_rd, c_rd_avail, c_rd_valid, c_full, c_ovf;
  logic [31:0] c_rd_data;
  logic [3:0]  c_level;
  logic        b_src_rd, b_rd_avail, b_rd_valid, b_full, b_ovf;
  logic [31:0] b_rd_data;
  logic [10:0] b_level;

  capture_buffer_ctrl #(.DATA_W(32), .ADDR_W(3), .WRAP_MODE(CAP_LINEAR)) u_lin (
    .clk(clk), .rst(rst), .src_empty(src_empty), .src_rd(l_src_rd), .src_data(src_data),
    .clear(clear), .rewind(rewind), .rd_en(rd_en), .rd_avail(l_rd_avail), .rd_data(l_rd_data),
    .rd_valid(l_rd_valid), .level(l_level), .full(l_full), .overflow(l_ovf));

  capture_buffer_ctrl #(.DATA_W(32), .ADDR_W(3), .WRAP_MODE(CAP_CIRCULAR)) u_cir (
    .clk(clk), .rst(rst), .src_empty(src_empty), .src_rd(c_src_rd), .src_data(src_data),
    .clear(clear), .rewind(rewind), .rd_en(rd_en), .rd_avail(c_rd_avail), .rd_data(c_rd_data),
    .rd_valid(c_rd_valid), .level(c_level), .full(c_full), .overflow(c_ovf));

  capture_buffer_ctrl u_big (
    .clk(clk), .rst(rst), .src_empty(src_empty), .src_rd(b_src_rd), .src_data(src_data),
    .clear(clear), .rewind(rewind), .rd_en(rd_en), .rd_avail(b_rd_avail), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .level(b_level), .full(b_full), .overflow(b_ovf));

  int          sel = 0;
  logic        o_src_rd, o_rd_avail, o_rd_valid, o_full, o_ovf;
  logic [31:0] o_rd_data;
  logic [10:0] o_level;

  always_comb begin
    o_src_rd = l_src_rd; o_rd_avail = l_rd_avail; o_rd_valid = l_rd_valid;
    o_full = l_full; o_ovf = l_ovf; o_rd_data = l_rd_data; o_level = 11'(l_level);
    if (sel == 1) begin
      o_src_rd = c_src_rd; o_rd_avail = c_rd_avail; o_rd_valid = c_rd_valid;
      o_full = c_full; o_ovf = c_ovf; o_rd_data = c_rd_data; o_level = 11'(c_level);
    end else if (sel == 2) begin
      o_src_rd = b_src_rd; o_rd_avail = b_rd_avail; o_rd_valid = b_rd_valid;
      o_full = b_full; o_ovf = b_ovf; o_rd_data = b_rd_data; o_level = b_level;
    end
  end

  // Model: every word ever written kept in order; the unread window is hist[rd_abs .. total-1],
  // never longer than depth.
  int          depth = 8;
  bit          wrap = 1'b0;
  logic [31:0] hist[$];
  logic [31:0] srcq[$];
  int          total, rd_abs;
  bit          m_pend, m_vld, m_ovf, hold;
  logic [31:0] m_pend_data, m_rdata;
  int          n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    total = 0; rd_abs = 0;
    m_pend = 1'b0; m_vld = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic cycle(input bit r, input bit clr, input bit rde, input bit rew);
    bit e, exp_rd, acc;
    int lvl;
    @(negedge clk);
    e = hold || (srcq.size() == 0);
    rst = r; clear = clr; rd_en = rde; rewind = rew; src_empty = e;
    src_data = m_pend ? m_pend_data : $urandom;
    #1;
    lvl    = total - rd_abs;
    exp_rd = !e && !r && !clr && (wrap || (lvl + int'(m_pend) < depth));
    chk("src_rd", o_src_rd, exp_rd);
    chk("rd_valid", o_rd_valid, m_vld && !r && !clr);
    if (m_vld && !r && !clr) chk("rd_data", o_rd_data, m_rdata);
    chk("level", o_level, lvl);
    chk("full", o_full, lvl == depth);
    chk("rd_avail", o_rd_avail, lvl != 0);
    chk("overflow", o_ovf, m_ovf);
    if (r || clr) begin
      model_reset();
    end else begin
      acc   = rde && (lvl != 0) && !rew;
      m_vld = acc;
      if (acc) begin
        m_rdata = hist[rd_abs];
        rd_abs++;
      end
      if (m_pend) begin
        hist.push_back(m_pend_data);
        total++;
        if (total - rd_abs > depth) begin
          rd_abs++;
          if (wrap) m_ovf = 1'b1;
        end
      end
      if (rew) rd_abs = (total > depth) ? total - depth : 0;
      m_pend = exp_rd;
      if (exp_rd) m_pend_data = srcq.pop_front();
    end
  endtask

  task automatic start_phase(input int s, input int d, input bit w);
    @(negedge clk);
    rst = 1'b1; clear = 1'b0; rd_en = 1'b0; rewind = 1'b0; src_empty = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sel = s; depth = d; wrap = w; hold = 1'b0;
    srcq.delete();
    model_reset();
  endtask

  task automatic push_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) srcq.push_back(base + 32'(i));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reads(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic random_run(input int n, input int rd_pct, input bit allow_kill);
    for (int i = 0; i < n; i++) begin
      if (srcq.size() < 4) srcq.push_back($urandom);
      hold = ($urandom_range(0, 9) < 4);
      cycle(allow_kill && ($urandom_range(0, 999) == 0),
            allow_kill && ($urandom_range(0, 499) == 0),
            ($urandom_range(0, 99) < rd_pct),
            ($urandom_range(0, 149) == 0));
    end
    hold = 1'b0;
  endtask

  initial begin
    // Linear, depth 8
    start_phase(0, 8, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    push_words(5, 32'hA0);
    idle(8);
    reads(5);
    idle(2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    push_words(10, 32'hB0);
    idle(14);
    chk("lin_full", o_full, 1'b1);
    chk("lin_no_ovf", o_ovf, 1'b0);
    reads(1);
    idle(4);
    reads(9);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    push_words(5, 32'hC0);
    idle(8);
    reads(3);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    reads(6);
    random_run(400, 50, 1'b1);

    // Circular, depth 8
    start_phase(1, 8, 1'b1);
    push_words(10, 32'h0);
    idle(14);
    chk("cir_ovf", o_ovf, 1'b1);
    reads(8);
    idle(1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    reads(9);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    push_words(8, 32'hD0);
    idle(11);
    push_words(1, 32'hE0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    push_words(1, 32'hF0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    random_run(400, 45, 1'b1);

    // Default parameters, pointer wrap over 1024 entries
    start_phase(2, 1024, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    random_run(1800, 15, 1'b0);
    random_run(1800, 75, 1'b0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
